// File: rtl/if_id_buffer.sv
// if_id_buffer: FIFO decoupling fetch from decode with valid/ready handshake and flush
module if_id_buffer #(
  parameter int width = 32,
  parameter int DEPTH = 2,
  parameter logic [width-1:0] NOP = width'(32'h00000013)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [width-1:0]         pc_in,
  input  logic [width-1:0]         pc_plus4_in,
  input  logic [width-1:0]         inst_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [width-1:0]         pc_out,
  output logic [width-1:0]         pc_plus4_out,
  output logic [width-1:0]         inst_out,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [width-1:0] pc_q [DEPTH];
  logic [width-1:0] pc4_q [DEPTH];
  logic [width-1:0] inst_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic push, pop;
  assign in_ready  = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign count     = count_q;
  assign pc_out       = out_valid ? pc_q[rd_ptr_q] : '0;
  assign pc_plus4_out = out_valid ? pc4_q[rd_ptr_q] : '0;
  assign inst_out     = out_valid ? inst_q[rd_ptr_q] : NOP;
  // next-state: flush wins over any handshake in the same cycle
  always_comb begin
    push     = in_valid & in_ready;
    pop      = out_valid & out_ready;
    count_d  = flush ? '0 : count_q + CW'(push) - CW'(pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
  end
  // occupancy and pointers; reset empties the buffer without a clock edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage is never cleared; empty outputs are masked instead
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_q[wr_ptr_q]   <= pc_in;
      pc4_q[wr_ptr_q]  <= pc_plus4_in;
      inst_q[wr_ptr_q] <= inst_in;
    end
  end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: scoreboard bench for the fetch/decode FIFO
module tb_if_id_buffer;
  localparam int D = 2;
  localparam logic [31:0] NOP = 32'h00000013;
  logic clk = 0, rst = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] pc_in = 0, pc_plus4_in = 0, inst_in = 0, pc_out, pc_plus4_out, inst_out;
  logic [1:0] count;
  logic [95:0] sb [$];
  int checks = 0, failures = 0;
  if_id_buffer dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .pc_in(pc_in), .pc_plus4_in(pc_plus4_in), .inst_in(inst_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out),
    .pc_plus4_out(pc_plus4_out), .inst_out(inst_out), .count(count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
    in_valid = v; pc_in = pc; pc_plus4_in = pc + 4; inst_in = pc ^ 32'h00500093;
    out_ready = rdy; flush = fl;
  endtask
  task automatic check_state();
    chk("count", 32'(count), 32'(sb.size()));
    chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(sb.size() < D));
    if (sb.size() == 0) begin
      chk("pc_empty", pc_out, 0);
      chk("pc4_empty", pc_plus4_out, 0);
      chk("inst_empty", inst_out, NOP);
    end else begin
      chk("pc_head", pc_out, sb[0][95:64]);
      chk("pc4_head", pc_plus4_out, sb[0][63:32]);
      chk("inst_head", inst_out, sb[0][31:0]);
    end
  endtask
  task automatic cycle();
    bit full;
    @(negedge clk);
    check_state();
    full = sb.size() == D;
    if (flush) sb.delete();
    else begin
      if (out_ready && sb.size() > 0) void'(sb.pop_front());
      if (in_valid && !full) sb.push_back({pc_in, pc_in + 32'd4, pc_in ^ 32'h00500093});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic first_scenario(input logic [31:0] pc);
    drive(1, pc, 1, 0); cycle();
    drive(0, 0, 1, 0); cycle();
    cycle();
  endtask
  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_pc", pc_out, 0);
    chk("rst_pc4", pc_plus4_out, 0);
    chk("rst_inst", inst_out, NOP);
    #10 rst = 1;
    @(posedge clk); #1;
    first_scenario(32'h00);
    for (int i = 0; i < 4; i++) begin drive(1, 32'(i * 4), 1, 0); cycle(); end
    drive(0, 0, 1, 0); cycle(); cycle();
    drive(1, 32'h10, 0, 0); cycle();
    drive(1, 32'h14, 0, 0); cycle();
    drive(1, 32'h18, 0, 0); cycle();
    drive(1, 32'h18, 1, 0); cycle();
    drive(1, 32'h18, 1, 0); cycle();
    drive(0, 0, 1, 0); cycle(); cycle(); cycle();
    drive(1, 32'h20, 0, 0); cycle();
    drive(1, 32'h24, 0, 0); cycle();
    drive(1, 32'h28, 1, 1); cycle();
    drive(0, 0, 1, 0); cycle();
    drive(0, 0, 0, 1); cycle();
    cycle(); cycle();
    drive(1, 32'h30, 0, 0); cycle();
    drive(1, 32'h34, 0, 0); cycle();
    drive(0, 0, 0, 0);
    chk("pre_areset_count", 32'(count), 2);
    #2 rst = 0;
    #1;
    chk("areset_out_valid", 32'(out_valid), 0);
    chk("areset_count", 32'(count), 0);
    chk("areset_inst", inst_out, NOP);
    sb.delete();
    rst = 1;
    cycle();
    first_scenario(32'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
